// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and constants for the two-requester I2C master.
//   i2c_state_e : transaction sequencer states
//   i2c_phase_e : quarter-bit phase Q0..Q3
//   I2C_ACK / I2C_NACK : SDA level of the acknowledge slot
//   BIT_CNT_W / BIT_LAST : width and terminal value of the in-byte bit counter
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_AACK,
    ST_DATA,
    ST_DACK,
    ST_STOP
  } i2c_state_e;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } i2c_phase_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam int                   BIT_CNT_W = 3;
  localparam logic [BIT_CNT_W-1:0] BIT_LAST  = '1;

endpackage

// File: rtl/i2c_bit_timer.sv
// i2c_bit_timer: quarter-bit timing for the I2C master.
// Optional feature macro: I2C_SCHED_STRETCH_EN (slave clock stretching in Q2).
//   clk, rst_n  : clock, asynchronous active-low reset
//   run_i       : 1 while a transaction is running; 0 parks the timer at Q0/count 0
//   scl_i       : sensed SCL line (used only with stretching enabled)
//   phase_o     : current quarter Q0..Q3
//   qtc_o       : last clk of the current quarter
//   bit_end_o   : last clk of the current bit (terminal count in Q3)
module i2c_bit_timer
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run_i,
  input  logic       scl_i,
  output i2c_phase_e phase_o,
  output logic       qtc_o,
  output logic       bit_end_o
);

  localparam int               CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  i2c_phase_e       phase_q, phase_d;
  logic             hold;
  logic             qtc;

`ifdef I2C_SCHED_STRETCH_EN
  // A slave keeping SCL low after the master released it holds Q2 at count 0,
  // so the sample point slides by exactly the stretch length.
  assign hold = (phase_q == Q2) && (cnt_q == '0) && !scl_i;
`else
  logic unused_scl;
  assign unused_scl = scl_i;
  assign hold       = 1'b0;
`endif

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    qtc     = 1'b0;
    if (!run_i) begin
      cnt_d   = '0;
      phase_d = Q0;
    end else if (!hold) begin
      if (cnt_q == LAST) begin
        cnt_d   = '0;
        phase_d = i2c_phase_e'(phase_q + 2'd1);
        qtc     = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= Q0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase_o   = phase_q;
  assign qtc_o     = qtc;
  assign bit_end_o = qtc && (phase_q == Q3);

endmodule

// File: rtl/i2c_master_sched.sv
// i2c_master_sched: two-requester single-byte I2C master with round-robin
// arbitration. Sequence: START, addr[6:0]+rw, ACK, data byte, ACK/NACK, STOP.
// Optional feature macro: I2C_SCHED_STRETCH_EN (see i2c_bit_timer).
//   clk, rst_n        : clock, asynchronous active-low reset
//   req[1:0]          : per-requester request level, held until done
//   addr[13:0]        : 7-bit address per requester (i uses [7i+6:7i])
//   rw[1:0]           : per-requester 0 = write, 1 = read
//   wdata[15:0]       : write byte per requester (i uses [8i+7:8i])
//   done[1:0]         : one-cycle pulse on the served requester's bit
//   nack              : address or write-data not acknowledged
//   rdata[7:0]        : read byte
//   busy              : transaction in progress
//   scl_in, sda_in    : bus line sense
//   scl_out, sda_out  : open-drain drive, 0 = pull low, 1 = release
module i2c_master_sched
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 250
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  input  logic [13:0] addr,
  input  logic [1:0]  rw,
  input  logic [15:0] wdata,
  output logic [1:0]  done,
  output logic        nack,
  output logic [7:0]  rdata,
  output logic        busy,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        scl_out,
  output logic        sda_out
);

  i2c_state_e           state_q, state_d;
  logic [1:0]           done_q;
  logic                 busy_q, nack_q, last_q, cur_q;
  logic [7:0]           rdata_q;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_idx;
  logic [6:0]           addr_q;
  logic                 rw_q;
  logic [7:0]           wdata_q, addr_byte;
  i2c_phase_e           phase;
  logic                 qtc, bit_end, sample, grant, gnt_idx, scl_hi;

  // Tie goes to the requester that was not served last.
  assign grant   = (state_q == ST_IDLE) && (req != 2'b00);
  assign gnt_idx = (req == 2'b11) ? ~last_q : req[1];

  assign sample    = qtc && (phase == Q2);
  assign bit_idx   = BIT_LAST - bit_cnt_q;
  assign addr_byte = {addr_q, rw_q};
  assign scl_hi    = (phase == Q2) || (phase == Q3);

  i2c_bit_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .run_i     (busy_q),
    .scl_i     (scl_in),
    .phase_o   (phase),
    .qtc_o     (qtc),
    .bit_end_o (bit_end)
  );

  always_comb begin
    state_d = state_q;
    scl_out = 1'b1;
    sda_out = 1'b1;
    if (state_q == ST_IDLE) begin
      if (grant) state_d = ST_START;
    end else if (bit_end) begin
      case (state_q)
        ST_START: state_d = ST_ADDR;
        ST_ADDR:  if (bit_cnt_q == BIT_LAST) state_d = ST_AACK;
        ST_AACK:  state_d = nack_q ? ST_STOP : ST_DATA;
        ST_DATA:  if (bit_cnt_q == BIT_LAST) state_d = ST_DACK;
        ST_DACK:  state_d = ST_STOP;
        default:  state_d = ST_IDLE;
      endcase
    end

    case (state_q)
      ST_START: sda_out = (phase == Q0) || (phase == Q1);
      ST_ADDR: begin
        scl_out = scl_hi;
        sda_out = addr_byte[bit_idx];
      end
      ST_DATA: begin
        scl_out = scl_hi;
        sda_out = rw_q ? 1'b1 : wdata_q[bit_idx];
      end
      // Both ACK slots release SDA: sampling the slave on writes, NACKing the
      // single read byte on reads.
      ST_AACK, ST_DACK: scl_out = scl_hi;
      ST_STOP: begin
        scl_out = (phase != Q0);
        sda_out = (phase == Q3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 2'b00;
      nack_q    <= 1'b0;
      rdata_q   <= 8'h00;
      last_q    <= 1'b1;
      cur_q     <= 1'b0;
      bit_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= 2'b00;
      if (grant) begin
        busy_q    <= 1'b1;
        nack_q    <= 1'b0;
        last_q    <= gnt_idx;
        cur_q     <= gnt_idx;
        bit_cnt_q <= '0;
      end
      if (bit_end) begin
        if (state_q == ST_ADDR || state_q == ST_DATA) bit_cnt_q <= bit_cnt_q + 1'b1;
        if (state_q == ST_STOP) begin
          busy_q <= 1'b0;
          done_q <= cur_q ? 2'b10 : 2'b01;
        end
      end
      if (sample) begin
        case (state_q)
          ST_AACK: if (sda_in == I2C_NACK) nack_q <= 1'b1;
          ST_DATA: if (rw_q) rdata_q <= {rdata_q[6:0], sda_in};
          ST_DACK: if (!rw_q && sda_in == I2C_NACK) nack_q <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Request fields are only meaningful once granted, so they carry no reset.
  always_ff @(posedge clk) begin
    if (grant) begin
      addr_q  <= gnt_idx ? addr[13:7]  : addr[6:0];
      rw_q    <= gnt_idx ? rw[1]       : rw[0];
      wdata_q <= gnt_idx ? wdata[15:8] : wdata[7:0];
    end
  end

  assign done  = done_q;
  assign nack  = nack_q;
  assign rdata = rdata_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_i2c_master_sched.sv
// tb_i2c_master_sched: self-checking bench for i2c_master_sched (CLK_DIV=4).
// A behavioural slave at address 0x51 watches the bus, ACKs its address,
// supplies read data and optionally NACKs write data; every SCL rise after
// START is recorded and compared with the bit stream expected from the
// transaction fields.
module tb_i2c_master_sched;

  localparam int         D   = 4;
  localparam logic [6:0] SLV = 7'h51;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic [13:0] addr;
  logic [1:0]  rw;
  logic [15:0] wdata;
  logic [1:0]  done;
  logic        nack;
  logic [7:0]  rdata;
  logic        busy;
  logic        scl_in, sda_in, scl_out, sda_out;

  logic slave_sda = 1'b1;
  logic stretch_n = 1'b1;
  logic stretch_arm = 1'b0;
  logic [7:0] slv_rdata = 8'h00;
  logic slv_dnack = 1'b0;

  assign scl_in = scl_out & stretch_n;
  assign sda_in = sda_out & slave_sda;

  i2c_master_sched #(.CLK_DIV(D)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .addr    (addr),
    .rw      (rw),
    .wdata   (wdata),
    .done    (done),
    .nack    (nack),
    .rdata   (rdata),
    .busy    (busy),
    .scl_in  (scl_in),
    .sda_in  (sda_in),
    .scl_out (scl_out),
    .sda_out (sda_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bus monitor and slave ----------------
  int          slot = -1;
  logic        in_xfer = 1'b0;
  logic        scl_p = 1'b1, sda_p = 1'b1;
  logic        slv_ack = 1'b0, slv_rw = 1'b0;
  logic [18:0] cap_vec = '0;
  int          ncap = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_xfer   = 1'b0;
      slot      = -1;
      slave_sda = 1'b1;
    end else if (scl_p && scl_in && sda_p && !sda_in) begin
      in_xfer = 1'b1;
      slot    = -1;
      cap_vec = '0;
      ncap    = 0;
      slv_ack = 1'b0;
      slv_rw  = 1'b0;
    end else if (scl_p && scl_in && !sda_p && sda_in) begin
      in_xfer   = 1'b0;
      slave_sda = 1'b1;
    end else if (in_xfer && scl_p && !scl_in) begin
      slot++;
      if (slot == 8) begin
        slv_ack = (cap_vec[7:1] == SLV);
        slv_rw  = cap_vec[0];
      end
      slave_sda = 1'b1;
      if (slot == 8 && slv_ack) slave_sda = 1'b0;
      else if (slot >= 9 && slot <= 16 && slv_ack && slv_rw) slave_sda = slv_rdata[16-slot];
      else if (slot == 17 && slv_ack && !slv_rw) slave_sda = slv_dnack;
    end else if (in_xfer && !scl_p && scl_in) begin
      cap_vec = {cap_vec[17:0], sda_in};
      ncap++;
    end
    scl_p = scl_in;
    sda_p = sda_in;
  end

  // Slave clock stretch: hold SCL low 37 clk after the master releases it in
  // address bit 3.
  always @(posedge scl_out) begin
    if (stretch_arm && in_xfer && slot == 3) begin
      stretch_n = 1'b0;
      repeat (37) @(posedge clk);
      #1 stretch_n = 1'b1;
    end
  end

  // ---------------- reference model ----------------
  // Bits seen at successive SCL rises after START, including the rise inside
  // STOP (SDA still low there).
  function automatic logic [18:0] model_bus(input logic [6:0] a, input logic r,
                                            input logic [7:0] wd, input logic [7:0] rdb,
                                            input logic dn);
    if (a != SLV) return {9'b0, a, r, 1'b1, 1'b0};
    return {a, r, 1'b0, (r ? rdb : wd), (r ? 1'b1 : dn), 1'b0};
  endfunction

  function automatic int model_nbits(input logic [6:0] a);
    return (a == SLV) ? 19 : 10;
  endfunction

  // ---------------- checking ----------------
  int nchecks = 0;
  int nerrors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_done(output logic [1:0] d, output int t);
    d = 2'b00;
    t = cyc;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (done != 2'b00) begin
        d = done;
        t = cyc;
        break;
      end
    end
    chk("done_seen", {31'b0, d != 2'b00}, 32'd1);
  endtask

  task automatic run_txn(input int idx, input logic [6:0] a, input logic r,
                         input logic [7:0] wd, input logic [7:0] rdb, input logic dn,
                         input int lat, input logic nk, input logic [7:0] rd);
    int         t0, t1;
    logic [1:0] d;
    slv_rdata = rdb;
    slv_dnack = dn;
    @(negedge clk);
    if (idx == 0) begin
      addr[6:0] = a; rw[0] = r; wdata[7:0] = wd; req = 2'b01;
    end else begin
      addr[13:7] = a; rw[1] = r; wdata[15:8] = wd; req = 2'b10;
    end
    t0 = cyc;
    @(negedge clk);
    chk("busy_after_grant", {31'b0, busy}, 32'd1);
    // Inputs must be ignored once granted.
    if (idx == 0) begin
      addr[6:0] = ~a; rw[0] = ~r; wdata[7:0] = ~wd;
    end else begin
      addr[13:7] = ~a; rw[1] = ~r; wdata[15:8] = ~wd;
    end
    wait_done(d, t1);
    chk("latency", t1 - t0, lat);
    chk("done_bit", {30'b0, d}, (idx == 0) ? 32'd1 : 32'd2);
    chk("nack", {31'b0, nack}, {31'b0, nk});
    chk("rdata", {24'b0, rdata}, {24'b0, rd});
    chk("busy_at_done", {31'b0, busy}, 32'd0);
    req = 2'b00;
    chk("bus_bits", {13'b0, cap_vec}, {13'b0, model_bus(a, r, wd, rdb, dn)});
    chk("bus_nbits", ncap, model_nbits(a));
    @(negedge clk);
    chk("nack_held", {31'b0, nack}, {31'b0, nk});
    chk("rdata_held", {24'b0, rdata}, {24'b0, rd});
  endtask

  typedef struct {
    int         idx;
    logic [6:0] a;
    logic       r;
    logic [7:0] wd;
    logic [7:0] rdb;
    logic       dn;
    int         lat;
    logic       nk;
    logic [7:0] rd;
  } vec_t;

  vec_t       tbl [6];
  logic [7:0] model_rd;
  int         t0, t1, tp, ridx;
  logic [1:0] d;
  logic [6:0] ra;
  logic       rr, rdn, rack, rnk;
  logic [7:0] rwd, rrdb;

  initial begin
    tbl[0] = '{0, 7'h51, 1'b0, 8'h5A, 8'h00, 1'b0, 1 + 80*D, 1'b0, 8'h00};
    tbl[1] = '{1, 7'h51, 1'b1, 8'h00, 8'hCA, 1'b0, 1 + 80*D, 1'b0, 8'hCA};
    tbl[2] = '{0, 7'h30, 1'b0, 8'hFF, 8'h00, 1'b0, 1 + 44*D, 1'b1, 8'hCA};
    tbl[3] = '{1, 7'h51, 1'b0, 8'h81, 8'h00, 1'b1, 1 + 80*D, 1'b1, 8'hCA};
    tbl[4] = '{1, 7'h30, 1'b1, 8'h00, 8'h55, 1'b0, 1 + 44*D, 1'b1, 8'hCA};
    tbl[5] = '{0, 7'h51, 1'b1, 8'h00, 8'h01, 1'b0, 1 + 80*D, 1'b0, 8'h01};

    rst_n = 1'b0; req = 2'b00; addr = '0; rw = '0; wdata = '0;
    #1;
    chk("rst_scl", {31'b0, scl_out}, 32'd1);
    chk("rst_sda", {31'b0, sda_out}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {30'b0, done}, 32'd0);
    chk("rst_nack", {31'b0, nack}, 32'd0);
    chk("rst_rdata", {24'b0, rdata}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_rd = 8'h00;

    for (int i = 0; i < 6; i++) begin
      run_txn(tbl[i].idx, tbl[i].a, tbl[i].r, tbl[i].wd, tbl[i].rdb, tbl[i].dn,
              tbl[i].lat, tbl[i].nk, tbl[i].rd);
      model_rd = tbl[i].rd;
    end

    for (int i = 0; i < 8; i++) begin
      ridx = int'($urandom_range(0, 1));
      ra   = ($urandom_range(0, 1) == 1) ? SLV : 7'($urandom);
      rr   = 1'($urandom);
      rwd  = 8'($urandom);
      rrdb = 8'($urandom);
      rdn  = 1'($urandom);
      rack = (ra == SLV);
      rnk  = !rack || (!rr && rdn);
      if (rack && rr) model_rd = rrdb;
      run_txn(ridx, ra, rr, rwd, rrdb, rdn, rack ? 1 + 80*D : 1 + 44*D, rnk, model_rd);
    end

`ifdef I2C_SCHED_STRETCH_EN
    stretch_arm = 1'b1;
    run_txn(0, SLV, 1'b1, 8'h00, 8'h96, 1'b0, 1 + 80*D + 37, 1'b0, 8'h96);
    stretch_arm = 1'b0;
    model_rd = 8'h96;
`endif

    // Reset in the middle of the data byte.
    @(negedge clk);
    addr[6:0] = SLV; rw[0] = 1'b0; wdata[7:0] = 8'hA5; req = 2'b01; slv_dnack = 1'b0;
    repeat (13*4*D + 6) @(negedge clk);
    chk("busy_before_rst", {31'b0, busy}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_scl", {31'b0, scl_out}, 32'd1);
    chk("midrst_sda", {31'b0, sda_out}, 32'd1);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_done", {30'b0, done}, 32'd0);
    req = 2'b00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_rdata", {24'b0, rdata}, 32'd0);
    run_txn(1, SLV, 1'b1, 8'h00, 8'h3C, 1'b0, 1 + 80*D, 1'b0, 8'h3C);

    // Round robin from reset with both requests held.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    addr = {SLV, SLV}; rw = 2'b00; wdata = 16'h3CC3; slv_dnack = 1'b0; req = 2'b11;
    t0 = cyc;
    tp = t0;
    for (int i = 0; i < 4; i++) begin
      wait_done(d, t1);
      chk("rr_grant", {30'b0, d}, (i % 2 == 1) ? 32'd2 : 32'd1);
      chk("rr_spacing", t1 - tp, 1 + 80*D);
      chk("rr_nack", {31'b0, nack}, 32'd0);
      tp = t1;
    end
    req = 2'b00;
    repeat (4) @(negedge clk);
    chk("rr_idle", {31'b0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule

// File: doc/i2c_master_sched.md
# i2c_master_sched

Two-requester I2C master that arbitrates single-byte transactions and sequences the bus. It generates START, the address/RW byte, one data byte with ACK slots, and STOP on open-drain SCL/SDA. It sits between on-chip requesters (the test controller and the config loader) and the external I2C bus shared with the `i2c_slave` instances. Fixed 4-quarter bit timing comes from a clock divider, with optional clock stretching.

## Interface
- `CLK_DIV`, default 250: clk cycles per quarter-bit; bit period = 4*CLK_DIV (100 kHz at 100 MHz). Legal range 2..1023.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  2  per-requester transaction request; level, held until `done`.
- `addr`  in  14  7-bit slave address per requester; requester i uses [7i+6:7i].
- `rw`  in  2  per requester: 0 = write, 1 = read.
- `wdata`  in  16  write byte per requester; requester i uses [8i+7:8i].
- `done`  out  2  one-cycle pulse on the served requester's bit.
- `nack`  out  1  1 = slave failed to ACK the address or the write data. Valid in the `done` cycle; held until the next grant.
- `rdata`  out  8  read byte. Valid in the `done` cycle; held until the next grant.
- `busy`  out  1  transaction in progress.
- `scl_in`, `sda_in`  in  1  bus line sense.
- `scl_out`, `sda_out`  out  1  open-drain drive: 0 = pull low, 1 = release.

## Operation
- Reset values: `scl_out`=1, `sda_out`=1, `busy`=0, `done`=0, `nack`=0, `rdata`=0, FSM=IDLE. The last-grant pointer resets to 1, so requester 0 wins the first tie.
- Arbitration happens only in IDLE. With one `req` high, that requester is granted. With both high, the requester that was not granted last wins (round-robin).
- On grant, the FSM latches `addr`, `rw` and `wdata`, then sets `busy`=1 and `nack`=0. Requester inputs are ignored until the next grant. Dropping `req` mid-transaction does not abort it; `done` still pulses.
- FSM states: IDLE → START → ADDR (8 bits: addr[6:0] MSB first, then rw) → AACK → DATA (8 bits) → DACK → STOP → IDLE.
- Each bit occupies 4 quarters:
  - Q0: SCL low; SDA updates at the Q0 start.
  - Q1: SCL low.
  - Q2: SCL released; `sda_in` is sampled at the last clk of Q2.
  - Q3: SCL released.
- START: SCL released throughout. SDA released in Q0–Q1, SDA low in Q2. SCL goes low at the end of Q3.
- STOP: SDA low in Q0–Q1. SCL released from Q1. SDA released in Q3.
- AACK: the master releases SDA. If the sample is 1, `nack`=1 and the FSM goes straight to STOP (DATA is skipped).
- DATA, write: the master drives `wdata` MSB first.
- DATA, read: the master releases SDA and shifts samples into `rdata` MSB first.
- DACK, write: the master samples the slave ACK; a sample of 1 sets `nack`=1.
- DACK, read: the master drives NACK (SDA released), because reads are single-byte.
- After STOP the FSM returns to IDLE. `done` pulses and `busy`=0 in that same cycle. A `req` seen in that cycle is eligible for arbitration.

## Timing
- Let the grant cycle be t. `busy`=1 at t+1, and the first quarter starts at t+1.
- Full transaction: 20 bit-times = 80*CLK_DIV clk. `done` pulses at t+1+80*CLK_DIV.
- Address NACK: 11 bit-times, so `done` pulses at t+1+44*CLK_DIV.
- The quarter counter counts 0..CLK_DIV-1. The phase advances on the cycle after the terminal count.
- Back-to-back: the next grant is possible in the `done` cycle, so there is no idle bit between STOP and the next START beyond that single cycle.
- Reset mid-transaction: both lines are released immediately (asynchronous) and no STOP is generated. The bus may be left with a partial transfer; this is by design.

## Configuration
- `I2C_SCHED_STRETCH_EN` defined:
  - In Q2, the quarter counter holds at 0 while `scl_in`=0, i.e. the slave stretches the clock.
  - Counting resumes on the first cycle `scl_in`=1, and the sample point moves accordingly.
  - There is no timeout.
- Undefined: `scl_in` is ignored and timing is exactly as stated above.

## Structure
- The package `i2c_pkg` holds:
  - the FSM state enum;
  - the quarter-phase encoding Q0..Q3;
  - constants `I2C_ACK`=0 and `I2C_NACK`=1;
  - the bit-count width.
- Sub-module `i2c_bit_timer` owns the quarter counter, the phase output, the terminal-count strobe and the stretch hold. The FSM, shift register and arbiter stay in `i2c_master_sched`.

## Test plan
- CLK_DIV=4, requester 0 writes 0x5A to address 0x51, slave ACKs both bytes:
  - SDA bit sequence is 1010001 0, then ACK, then 01011010, then ACK.
  - `done`=01 at t+1+320; `nack`=0.
- Requester 1 reads from 0x51; the slave drives 0xCA:
  - `rdata`=0xCA and `nack`=0 at `done`=10.
  - The master releases SDA in the DACK slot.
- Address 0x30 with no ACK (SDA stays high): `nack`=1, no DATA bits on the bus, `done` at t+1+176.
- Both `req` high from reset and held high: grants alternate 0, 1, 0, 1 across four consecutive transactions, one cycle apart at each `done`.
- With `I2C_SCHED_STRETCH_EN`, the slave holds SCL low 37 cycles during address bit 3: `done` arrives exactly 37 cycles later than the unstretched case, and data is correct.
- `rst_n` asserted mid-DATA: `scl_out`=`sda_out`=1 and `busy`=0 immediately. After release, a new `req` completes normally.
